// File: rtl/control_unit_seq_pkg.sv
// Shared encodings for the registered ID-stage control unit: instruction
// modes, data-processing opcodes, EXE_CMD codes, sequencer states and the
// packed control word that sits in the ID/EXE output register.
package arm_ctrl_pkg;

  localparam int NUM_REGS   = 16;
  localparam int WORD_BYTES = 4;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_UND = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  // Everything in the output register except the parameter-width index/offset.
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b_out;
    logic       s_out;
    logic       uop_valid;
    logic       uop_last;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(12'h000);

  // ALU command for a data-processing opcode; unlisted opcodes behave as MOV.
  function automatic logic [3:0] dp_exe_cmd(input logic [3:0] op);
    logic [3:0] cmd;
    case (op)
      OP_MOV:  cmd = EXE_MOV;
      OP_MVN:  cmd = EXE_MVN;
      OP_ADD:  cmd = EXE_ADD;
      OP_ADC:  cmd = EXE_ADC;
      OP_SUB:  cmd = EXE_SUB;
      OP_SBC:  cmd = EXE_SBC;
      OP_AND:  cmd = EXE_AND;
      OP_ORR:  cmd = EXE_ORR;
      OP_EOR:  cmd = EXE_EOR;
      OP_CMP:  cmd = EXE_SUB;
      OP_TST:  cmd = EXE_AND;
      default: cmd = EXE_MOV;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/control_unit_seq_if.sv
// Decode-side bundle between the IF/ID register, the control unit and EXE.
// master = the upstream driver of decode inputs, slave = the control unit.
interface control_unit_seq_if
  import arm_ctrl_pkg::*;
#(
  parameter int NUM_REGS_P   = NUM_REGS,
  parameter int WORD_BYTES_P = WORD_BYTES,
  parameter int REG_IDX_W    = $clog2(NUM_REGS_P),
  parameter int OFFSET_W     = REG_IDX_W + $clog2(WORD_BYTES_P) + 1
);
  logic                  in_valid;
  logic                  stall_in;
  logic                  flush;
  logic [1:0]            mode;
  logic [3:0]            op_code;
  logic                  s_in;
  logic                  blk_xfer;
  logic                  up_in;
  logic [NUM_REGS_P-1:0] reg_list;

  logic [3:0]            exe_cmd;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  wb_en;
  logic                  b_out;
  logic                  s_out;
  logic                  uop_valid;
  logic [REG_IDX_W-1:0]  uop_reg;
  logic [OFFSET_W-1:0]   uop_offset;
  logic                  uop_last;
  logic                  illegal;
  logic                  busy;

  modport master (
    output in_valid, stall_in, flush, mode, op_code, s_in, blk_xfer, up_in, reg_list,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, b_out, s_out,
           uop_valid, uop_reg, uop_offset, uop_last, illegal, busy
  );

  modport slave (
    input  in_valid, stall_in, flush, mode, op_code, s_in, blk_xfer, up_in, reg_list,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, b_out, s_out,
           uop_valid, uop_reg, uop_offset, uop_last, illegal, busy
  );
endinterface

// File: rtl/control_unit_seq_ffs_lsb.sv
// Combinational find-lowest-set-bit: index of the least significant 1 in
// vec_i and a flag telling whether any bit was set at all.
module ffs_lsb #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/control_unit_seq.sv
// Registered ID-stage control unit. Single-uop instructions are decoded and
// registered in one cycle; LDM/STM are expanded by a small sequencer into one
// micro-op per listed register, walking the mask lowest-bit first while an
// accumulator tracks the byte offset from the base register.
module control_unit_seq
  import arm_ctrl_pkg::*;
#(
  parameter int NUM_REGS_P   = NUM_REGS,
  parameter int WORD_BYTES_P = WORD_BYTES
) (
  input logic               clk,
  input logic               rst,
  control_unit_seq_if.slave bus
);

  localparam int REG_IDX_W = $clog2(NUM_REGS_P);
  localparam int OFFSET_W  = REG_IDX_W + $clog2(WORD_BYTES_P) + 1;
  localparam logic signed [OFFSET_W-1:0] STRIDE = OFFSET_W'(WORD_BYTES_P);

  state_e                       state_q, state_d;
  logic [NUM_REGS_P-1:0]        mask_q, mask_d;
  logic                         l_q, l_d;
  logic                         up_q, up_d;
  logic signed [OFFSET_W-1:0]   offset_q, offset_d;
  ctrl_t                        ctrl_q, ctrl_d;
  logic [REG_IDX_W-1:0]         uop_reg_q, uop_reg_d;
  logic [OFFSET_W-1:0]          uop_offset_q, uop_offset_d;

  logic [NUM_REGS_P-1:0]        scan_s;
  logic [NUM_REGS_P-1:0]        remain_s;
  logic [REG_IDX_W-1:0]         lsb_idx_s;
  logic                         lsb_found_s;
  logic signed [OFFSET_W-1:0]   next_off_s;

  // In SEQ the pending mask is walked; in IDLE a fresh register list is examined.
  assign scan_s = (state_q == ST_SEQ) ? mask_q : bus.reg_list;

  ffs_lsb #(.N(NUM_REGS_P), .IDX_W(REG_IDX_W)) u_ffs (
    .vec_i   (scan_s),
    .idx_o   (lsb_idx_s),
    .found_o (lsb_found_s)
  );

  // Next-state, sequencer bookkeeping and decoded output word.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    l_d          = l_q;
    up_d         = up_q;
    offset_d     = offset_q;
    ctrl_d       = ctrl_q;
    uop_reg_d    = uop_reg_q;
    uop_offset_d = uop_offset_q;
    remain_s     = scan_s;
    remain_s[lsb_idx_s] = 1'b0;
    next_off_s   = up_q ? (offset_q + STRIDE) : (offset_q - STRIDE);

    if (bus.flush) begin
      ctrl_d       = CTRL_BUBBLE;
      uop_reg_d    = '0;
      uop_offset_d = '0;
      state_d      = ST_IDLE;
      mask_d       = '0;
      offset_d     = '0;
    end else if (bus.stall_in) begin
      // Hazard stall: every register keeps its value (defaults above).
      state_d = state_q;
    end else begin
      ctrl_d       = CTRL_BUBBLE;
      uop_reg_d    = '0;
      uop_offset_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            case (bus.mode)
              MODE_DP: begin
                ctrl_d.exe_cmd   = dp_exe_cmd(bus.op_code);
                ctrl_d.s_out     = bus.s_in;
                ctrl_d.wb_en     = !((bus.op_code == OP_CMP) || (bus.op_code == OP_TST));
                ctrl_d.uop_valid = 1'b1;
                ctrl_d.uop_last  = 1'b1;
              end
              MODE_MEM: begin
                ctrl_d.exe_cmd   = EXE_ADD;
                ctrl_d.mem_r_en  = bus.s_in;
                ctrl_d.wb_en     = bus.s_in;
                ctrl_d.mem_w_en  = !bus.s_in;
                ctrl_d.uop_valid = 1'b1;
                ctrl_d.uop_last  = 1'b1;
              end
              MODE_BR: begin
                if (!bus.blk_xfer) begin
                  ctrl_d.b_out     = 1'b1;
                  ctrl_d.uop_valid = 1'b1;
                  ctrl_d.uop_last  = 1'b1;
                end else if (lsb_found_s) begin
                  ctrl_d.exe_cmd   = EXE_ADD;
                  ctrl_d.mem_r_en  = bus.s_in;
                  ctrl_d.wb_en     = bus.s_in;
                  ctrl_d.mem_w_en  = !bus.s_in;
                  ctrl_d.uop_valid = 1'b1;
                  uop_reg_d        = lsb_idx_s;
                  l_d              = bus.s_in;
                  up_d             = bus.up_in;
                  offset_d         = '0;
                  mask_d           = remain_s;
                  if (remain_s != '0) begin
                    state_d = ST_SEQ;
                  end else begin
                    ctrl_d.uop_last = 1'b1;
                  end
                end else begin
                  // Empty register list decodes to a bubble.
                  ctrl_d = CTRL_BUBBLE;
                end
              end
              MODE_UND: ctrl_d.illegal = 1'b1;
              default:  ctrl_d = CTRL_BUBBLE;
            endcase
          end else begin
            ctrl_d = CTRL_BUBBLE;
          end
        end
        ST_SEQ: begin
          ctrl_d.exe_cmd   = EXE_ADD;
          ctrl_d.mem_r_en  = l_q;
          ctrl_d.wb_en     = l_q;
          ctrl_d.mem_w_en  = !l_q;
          ctrl_d.uop_valid = 1'b1;
          uop_reg_d        = lsb_idx_s;
          uop_offset_d     = next_off_s;
          offset_d         = next_off_s;
          mask_d           = remain_s;
          if (remain_s == '0) begin
            ctrl_d.uop_last = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            state_d = ST_SEQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ID/EXE pipeline register and sequencer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      l_q          <= 1'b0;
      up_q         <= 1'b0;
      offset_q     <= '0;
      ctrl_q       <= CTRL_BUBBLE;
      uop_reg_q    <= '0;
      uop_offset_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      l_q          <= l_d;
      up_q         <= up_d;
      offset_q     <= offset_d;
      ctrl_q       <= ctrl_d;
      uop_reg_q    <= uop_reg_d;
      uop_offset_q <= uop_offset_d;
    end
  end

  assign bus.exe_cmd    = ctrl_q.exe_cmd;
  assign bus.mem_r_en   = ctrl_q.mem_r_en;
  assign bus.mem_w_en   = ctrl_q.mem_w_en;
  assign bus.wb_en      = ctrl_q.wb_en;
  assign bus.b_out      = ctrl_q.b_out;
  assign bus.s_out      = ctrl_q.s_out;
  assign bus.uop_valid  = ctrl_q.uop_valid;
  assign bus.uop_last   = ctrl_q.uop_last;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.uop_reg    = uop_reg_q;
  assign bus.uop_offset = uop_offset_q;
  assign bus.busy       = (state_q == ST_SEQ);

endmodule

// File: tb/tb_control_unit_seq.sv
// Scoreboard bench for control_unit_seq: the driver pushes hand-computed
// expected micro-ops as it issues instructions; a monitor pops and compares
// whenever the DUT presents a micro-op or an illegal pulse.
module tb_control_unit_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  control_unit_seq_if bus_if ();

  control_unit_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [22:0] exp_q[$];
  string       name_q[$];
  logic [22:0] act_s;

  // {exe_cmd, mem_r, mem_w, wb, b, s, valid, reg[3:0], offset[6:0], last, illegal}
  assign act_s = {bus_if.exe_cmd, bus_if.mem_r_en, bus_if.mem_w_en, bus_if.wb_en,
                  bus_if.b_out, bus_if.s_out, bus_if.uop_valid, bus_if.uop_reg,
                  bus_if.uop_offset, bus_if.uop_last, bus_if.illegal};

  function automatic logic [22:0] mk(input logic [3:0] cmd, input logic r, input logic w,
                                     input logic wb, input logic b, input logic s,
                                     input logic v, input logic [3:0] rg,
                                     input logic [6:0] off, input logic last,
                                     input logic ill);
    return {cmd, r, w, wb, b, s, v, rg, off, last, ill};
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_uop(input string nm, input logic [22:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic bx, input logic up, input logic [15:0] rl);
    bus_if.mode     = m;
    bus_if.op_code  = op;
    bus_if.s_in     = s;
    bus_if.blk_xfer = bx;
    bus_if.up_in    = up;
    bus_if.reg_list = rl;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
  endtask

  // Monitor: compare every presented micro-op against the scoreboard head.
  initial begin
    logic        stall_e;
    logic [22:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      stall_e = bus_if.stall_in && !bus_if.flush;
      @(negedge clk);
      if (!rst && (bus_if.uop_valid || bus_if.illegal) && !stall_e) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_uop", act_s, 23'h0);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk(nm, act_s, e);
        end
      end
    end
  end

  // Driver: directed vectors with hand-computed expectations.
  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.stall_in = 1'b0;
    bus_if.flush    = 1'b0;
    bus_if.mode     = 2'b00;
    bus_if.op_code  = 4'b0000;
    bus_if.s_in     = 1'b0;
    bus_if.blk_xfer = 1'b0;
    bus_if.up_in    = 1'b0;
    bus_if.reg_list = 16'h0000;

    #12;
    chk("reset_outputs", act_s, 23'h0);
    chk("reset_busy", {22'h0, bus_if.busy}, 23'h0);
    step();
    rst = 1'b0;
    step();

    // Single-uop decodes.
    expect_uop("add_s1", mk(4'b0010, 0, 0, 1, 0, 1, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_uop("cmp",    mk(4'b0100, 0, 0, 0, 0, 1, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b1010, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_uop("tst",    mk(4'b0110, 0, 0, 0, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_uop("mvn",    mk(4'b1001, 0, 0, 1, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b1111, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_uop("eor",    mk(4'b1000, 0, 0, 1, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_uop("sbc",    mk(4'b0101, 0, 0, 1, 0, 1, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b0110, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_uop("other_op", mk(4'b0001, 0, 0, 1, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b0011, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_uop("ldr",    mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_uop("str",    mk(4'b0010, 0, 1, 0, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    expect_uop("branch", mk(4'b0000, 0, 0, 0, 1, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);

    // Undefined mode: one-cycle illegal pulse.
    expect_uop("undef",  mk(4'b0000, 0, 0, 0, 0, 0, 0, 4'd0, 7'd0, 0, 1));
    issue(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    chk("illegal_pulse_end", {22'h0, bus_if.illegal}, 23'h0);

    // Block transfer with empty list is a bubble.
    issue(2'b10, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("blk_empty_bubble", act_s, 23'h0);
    chk("blk_empty_busy", {22'h0, bus_if.busy}, 23'h0);

    // LDM up, list 0x0029: regs 0/3/5 at offsets 0/4/8; inputs ignored in SEQ.
    expect_uop("ldm_r0", mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd0, 7'd0, 0, 0));
    expect_uop("ldm_r3", mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd3, 7'd4, 0, 0));
    expect_uop("ldm_r5", mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd5, 7'd8, 1, 0));
    issue(2'b10, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h0029);
    chk("ldm_busy1", {22'h0, bus_if.busy}, 23'h1);
    bus_if.mode = 2'b00; bus_if.op_code = 4'b1101; bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    chk("ldm_busy2", {22'h0, bus_if.busy}, 23'h1);
    step();
    chk("ldm_busy_done", {22'h0, bus_if.busy}, 23'h0);
    step();

    // STM down, list 0x8001, stalled three cycles mid-sequence.
    expect_uop("stm_r0",  mk(4'b0010, 0, 1, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0));
    expect_uop("stm_r15", mk(4'b0010, 0, 1, 0, 0, 0, 1, 4'd15, 7'h7C, 1, 0));
    issue(2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h8001);
    bus_if.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_frozen", act_s, mk(4'b0010, 0, 1, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0));
      chk("stall_busy", {22'h0, bus_if.busy}, 23'h1);
    end
    bus_if.stall_in = 1'b0;
    step();
    chk("stm_busy_done", {22'h0, bus_if.busy}, 23'h0);
    step();

    // Flush during SEQ of 0x00F0 after reg 4; a same-cycle instruction is dropped.
    expect_uop("flush_r4", mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd4, 7'd0, 0, 0));
    issue(2'b10, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h00F0);
    bus_if.flush = 1'b1;
    bus_if.mode = 2'b00; bus_if.op_code = 4'b0100; bus_if.blk_xfer = 1'b0;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.flush = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("flush_bubble", act_s, 23'h0);
    chk("flush_busy", {22'h0, bus_if.busy}, 23'h0);
    step(); step(); step();

    // Asynchronous reset mid-sequence, asserted away from the clock edge.
    issue(2'b10, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h0007);
    chk("pre_rst_uop", act_s, mk(4'b0010, 1, 0, 1, 0, 0, 1, 4'd0, 7'd0, 0, 0));
    chk("pre_rst_busy", {22'h0, bus_if.busy}, 23'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", act_s, 23'h0);
    chk("async_rst_busy", {22'h0, bus_if.busy}, 23'h0);
    step();
    #2;
    rst = 1'b0;
    step(); step();

    // Recovery after reset.
    expect_uop("add_after_rst", mk(4'b0010, 0, 0, 1, 0, 0, 1, 4'd0, 7'd0, 1, 0));
    issue(2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h0);
    step(); step();

    chk("scoreboard_drained", 23'(exp_q.size()), 23'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
